// File: rtl/maxnet_pkg.sv
// ---------------------------------------------------------------------------
// maxnet_pkg
// Shared definitions for the Maxnet sequencing controller:
//   - maxnet_state_e : controller FSM state type and encoding
//   - DEF_*          : default parameter values for maxnet_ctrl
//   - wait_cnt_width : width of the WAIT down-counter for a given PU latency
// ---------------------------------------------------------------------------
package maxnet_pkg;

    localparam int unsigned DEF_CNT_W      = 8;
    localparam int unsigned DEF_MAX_ITER   = 64;
    localparam int unsigned DEF_PU_LATENCY = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_FINISH = 3'd5
    } maxnet_state_e;

    // The WAIT counter only ever holds values 0 .. PU_LATENCY-1.
    function automatic int unsigned wait_cnt_width(input int unsigned pu_latency);
        return (pu_latency > 1) ? $clog2(pu_latency) : 1;
    endfunction

endpackage

// File: rtl/maxnet_wait_counter.sv
// ---------------------------------------------------------------------------
// maxnet_wait_counter
// Loadable down-counter with a zero flag; times the WAIT state of the
// Maxnet controller while the processing-unit/ReLU network settles.
// Ports:
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset (count -> 0)
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one; holds at zero
//   zero_o     : count is zero
// ---------------------------------------------------------------------------
module maxnet_wait_counter #(
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/maxnet_ctrl.sv
// ---------------------------------------------------------------------------
// maxnet_ctrl
// Sequencing controller for the Maxnet datapath. On start it loads the input
// samples (LOAD), then loops CHECK -> WAIT -> UPDATE until the datapath reports
// a single survivor, all-zero values, or the iteration limit is hit, and then
// presents a held result-valid handshake with status flags (FINISH).
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   start      : run request, sampled in IDLE only
//   abort      : cancel run; in FINISH acts as resAck
//   dpDone     : datapath converged (one nonzero working value)
//   dpZero     : all working values zero
//   resAck     : consumer accepts the result
//   ldX        : load X register (LOAD)
//   ldTmp      : load working register (LOAD, UPDATE)
//   selTmp     : working register source: 0 = inputs, 1 = ReLU outputs
//   ready      : controller idle
//   busy       : run in progress
//   valid      : result available, held until resAck
//   timeout    : last run ended on the iteration limit
//   zeroErr    : last run ended with all values zero
//   iterCount  : UPDATE cycles in the current or last run (saturating)
// ---------------------------------------------------------------------------
module maxnet_ctrl
    import maxnet_pkg::*;
#(
    parameter int unsigned PU_LATENCY = DEF_PU_LATENCY,
    parameter int unsigned MAX_ITER   = DEF_MAX_ITER,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dpDone,
    input  logic             dpZero,
    input  logic             resAck,
    output logic             ldX,
    output logic             ldTmp,
    output logic             selTmp,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic             timeout,
    output logic             zeroErr,
    output logic [CNT_W-1:0] iterCount
);

    localparam int unsigned         WAIT_W     = wait_cnt_width(PU_LATENCY);
    localparam logic [WAIT_W-1:0]   WAIT_LOAD  = (PU_LATENCY > 0) ? WAIT_W'(PU_LATENCY - 1) : '0;
    localparam logic [CNT_W-1:0]    ITER_LIMIT = CNT_W'(MAX_ITER);

    maxnet_state_e    state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             timeout_q, timeout_d;
    logic             zero_err_q, zero_err_d;

    logic             wait_load;
    logic             wait_dec;
    logic             wait_zero;

    maxnet_wait_counter #(
        .W (WAIT_W)
    ) u_wait_counter (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (wait_load),
        .load_val_i (WAIT_LOAD),
        .dec_i      (wait_dec),
        .zero_o     (wait_zero)
    );

    // Next-state, iteration counter and flags
    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        timeout_d  = timeout_q;
        zero_err_d = zero_err_q;
        wait_load  = 1'b0;
        wait_dec   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // An abort here leaves the previous run's status untouched.
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    iter_d     = '0;
                    timeout_d  = 1'b0;
                    zero_err_d = 1'b0;
                    state_d    = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (dpDone) begin
                    state_d = ST_FINISH;
                end else if (dpZero) begin
                    zero_err_d = 1'b1;
                    state_d    = ST_FINISH;
                end else if (iter_q == ITER_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FINISH;
                end else if (PU_LATENCY == 0) begin
                    state_d = ST_UPDATE;
                end else begin
                    wait_load = 1'b1;
                    state_d   = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (wait_zero) begin
                    state_d = ST_UPDATE;
                end else begin
                    wait_dec = 1'b1;
                end
            end

            ST_UPDATE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (iter_q != ITER_LIMIT) begin
                        iter_d = iter_q + CNT_W'(1);
                    end
                    state_d = ST_CHECK;
                end
            end

            ST_FINISH: begin
                if (resAck || abort) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            iter_q     <= '0;
            timeout_q  <= 1'b0;
            zero_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            timeout_q  <= timeout_d;
            zero_err_q <= zero_err_d;
        end
    end

    // Moore outputs
    always_comb begin
        ldX    = 1'b0;
        ldTmp  = 1'b0;
        selTmp = 1'b0;
        ready  = 1'b0;
        busy   = 1'b0;
        valid  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
            end
            ST_LOAD: begin
                busy  = 1'b1;
                ldX   = 1'b1;
                ldTmp = 1'b1;
            end
            ST_CHECK, ST_WAIT: begin
                busy = 1'b1;
            end
            ST_UPDATE: begin
                busy   = 1'b1;
                ldTmp  = 1'b1;
                selTmp = 1'b1;
            end
            ST_FINISH: begin
                valid = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign timeout   = timeout_q;
    assign zeroErr   = zero_err_q;
    assign iterCount = iter_q;

endmodule

// File: tb/tb_maxnet_ctrl.sv
// ---------------------------------------------------------------------------
// tb_maxnet_ctrl
// Four controller instances with different parameters, each driving its own
// behavioural datapath stub:
//   0 : PU_LATENCY=1, MAX_ITER=64
//   1 : PU_LATENCY=1, MAX_ITER=4
//   2 : PU_LATENCY=0, MAX_ITER=64
//   3 : PU_LATENCY=3, MAX_ITER=64
// Each launched run pushes its expected result (valid cycle, iterCount,
// flags) onto a queue; a monitor pops and compares on every valid rising.
// Cycle c is the clock period following rising edge c-1; a start sampled at
// edge k therefore gives LOAD in cycle k+1.
// ---------------------------------------------------------------------------
module tb_maxnet_ctrl;

    localparam int NINST = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] start, abort, resAck, dpDone, dpZero;
    logic [3:0] ldX, ldTmp, selTmp, ready, busy, valid, timeout, zeroErr;
    logic [7:0] iterCount [NINST];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int id;
        int vcyc;
        int iter;
        int tout;
        int zerr;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- DUTs ----------------
    for (genvar g = 0; g < NINST; g++) begin : g_dut
        localparam int unsigned PL = (g == 2) ? 0 : ((g == 3) ? 3 : 1);
        localparam int unsigned MI = (g == 1) ? 4 : 64;
        maxnet_ctrl #(
            .PU_LATENCY (PL),
            .MAX_ITER   (MI),
            .CNT_W      (8)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start[g]),
            .abort     (abort[g]),
            .dpDone    (dpDone[g]),
            .dpZero    (dpZero[g]),
            .resAck    (resAck[g]),
            .ldX       (ldX[g]),
            .ldTmp     (ldTmp[g]),
            .selTmp    (selTmp[g]),
            .ready     (ready[g]),
            .busy      (busy[g]),
            .valid     (valid[g]),
            .timeout   (timeout[g]),
            .zeroErr   (zeroErr[g]),
            .iterCount (iterCount[g])
        );
    end

    // ---------------- datapath stub ----------------
    // Counts working-register updates since the last ldX; reports convergence
    // or all-zero once the count reaches the configured thresholds.
    int upd_n   [NINST] = '{default: 0};
    int done_at [NINST] = '{default: 1000};
    int zero_at [NINST] = '{default: 1000};

    always @(posedge clk) begin
        for (int i = 0; i < NINST; i++) begin
            if (ldX[i])
                upd_n[i] <= 0;
            else if (ldTmp[i] && selTmp[i])
                upd_n[i] <= upd_n[i] + 1;
        end
    end

    always_comb begin
        dpDone = '0;
        dpZero = '0;
        for (int i = 0; i < NINST; i++) begin
            dpDone[i] = (upd_n[i] >= done_at[i]);
            dpZero[i] = (upd_n[i] >= zero_at[i]);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    logic [3:0] vprev = '0;
    always @(negedge clk) begin
        for (int i = 0; i < NINST; i++) begin
            if (valid[i] && !vprev[i]) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("spurious_valid_%0d", i), int'(valid[i]), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result_inst", i, e.id);
                    chk($sformatf("valid_cycle_%0d", i), cyc, e.vcyc);
                    chk($sformatf("iterCount_%0d", i), int'(iterCount[i]), e.iter);
                    chk($sformatf("timeout_%0d", i), int'(timeout[i]), e.tout);
                    chk($sformatf("zeroErr_%0d", i), int'(zeroErr[i]), e.zerr);
                    chk($sformatf("busy_in_finish_%0d", i), int'(busy[i]), 0);
                end
            end
        end
        vprev <= valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue start on instance i; expected valid cycle is k+voff.
    // Returns in the LOAD cycle (k+1).
    task automatic launch(input int i, input int voff, input int it, input int to,
                          input int ze, output int k);
        exp_t e;
        k       = cyc;
        e.id    = i;
        e.vcyc  = k + voff;
        e.iter  = it;
        e.tout  = to;
        e.zerr  = ze;
        exp_q.push_back(e);
        start[i] = 1'b1;
        tick(1);
        start[i] = 1'b0;
    endtask

    // From the LOAD cycle, follow the run until valid, checking the update pulses.
    task automatic count_pulses(input int i, input int n_exp, input int spacing,
                                input int first_off, input int k);
        int np   = 0;
        int last = 0;
        int n    = 0;
        while (!valid[i] && n < 400) begin
            if (ldTmp[i] && selTmp[i]) begin
                if (np == 0)
                    chk("first_update_cycle", cyc - k, first_off);
                else
                    chk("update_spacing", cyc - last, spacing);
                np++;
                last = cyc;
            end
            tick(1);
            n++;
        end
        chk("valid_reached", int'(valid[i]), 1);
        chk("update_pulses", np, n_exp);
    endtask

    task automatic wait_valid(input int i, input int budget);
        int n = 0;
        while (!valid[i] && n < budget) begin
            tick(1);
            n++;
        end
        chk("valid_reached", int'(valid[i]), 1);
    endtask

    task automatic ack(input int i);
        resAck[i] = 1'b1;
        tick(1);
        resAck[i] = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int k;
        rst    = 1'b0;
        start  = '0;
        abort  = '0;
        resAck = '0;
        tick(3);

        // Reset state
        for (int i = 0; i < NINST; i++) begin
            chk("rst_ready", int'(ready[i]), 1);
            chk("rst_busy", int'(busy[i]), 0);
            chk("rst_valid", int'(valid[i]), 0);
            chk("rst_iter", int'(iterCount[i]), 0);
            chk("rst_ctrl", int'({ldX[i], ldTmp[i], selTmp[i]}), 0);
            chk("rst_flags", int'({timeout[i], zeroErr[i]}), 0);
        end
        rst = 1'b1;
        tick(1);

        // Reset mid-WAIT (inst 3, PU_LATENCY=3): second WAIT spans k+8..k+10
        k = cyc;
        start[3] = 1'b1;
        tick(1);
        start[3] = 1'b0;
        tick(8);
        chk("midwait_busy", int'(busy[3]), 1);
        chk("midwait_iter", int'(iterCount[3]), 1);
        chk("midwait_noupd", int'(ldTmp[3]), 0);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        chk("midrst_ready", int'(ready[3]), 1);
        chk("midrst_busy", int'(busy[3]), 0);
        chk("midrst_iter", int'(iterCount[3]), 0);
        chk("midrst_valid", int'(valid[3]), 0);
        tick(2);

        // Inst 0: converge after 5 updates -> valid at k+18
        done_at[0] = 5;
        zero_at[0] = 1000;
        launch(0, 18, 5, 0, 0, k);
        chk("load_ldX", int'(ldX[0]), 1);
        chk("load_ldTmp", int'(ldTmp[0]), 1);
        chk("load_selTmp", int'(selTmp[0]), 0);
        count_pulses(0, 5, 3, 4, k);

        // Hold valid without resAck; start pulsed meanwhile is ignored
        for (int j = 0; j < 10; j++) begin
            chk("valid_held", int'(valid[0]), 1);
            chk("not_ready_in_finish", int'(ready[0]), 0);
            start[0] = (j == 3);
            tick(1);
        end
        start[0] = 1'b0;
        chk("valid_still_held", int'(valid[0]), 1);
        ack(0);
        chk("ack_ready", int'(ready[0]), 1);
        chk("ack_valid", int'(valid[0]), 0);
        chk("iter_held_idle", int'(iterCount[0]), 5);

        // All-zero on second CHECK -> zeroErr, iterCount=1, valid at k+6
        done_at[0] = 1000;
        zero_at[0] = 1;
        launch(0, 6, 1, 0, 1, k);
        wait_valid(0, 50);
        ack(0);  // resAck in the cycle valid first rises
        chk("same_cycle_ack_ready", int'(ready[0]), 1);
        chk("zeroErr_held", int'(zeroErr[0]), 1);

        // Back-to-back start in first IDLE cycle; dpDone and dpZero together
        done_at[0] = 1;
        zero_at[0] = 1;
        launch(0, 6, 1, 0, 0, k);
        tick(1);
        chk("flags_cleared_zero", int'(zeroErr[0]), 0);
        chk("flags_cleared_iter", int'(iterCount[0]), 0);
        wait_valid(0, 50);
        ack(0);

        // Abort in UPDATE (UPDATE at k+4) -> IDLE, no valid
        done_at[0] = 1000;
        zero_at[0] = 1000;
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        tick(3);
        chk("abort_in_update", int'(selTmp[0]), 1);
        abort[0] = 1'b1;
        tick(1);
        abort[0] = 1'b0;
        chk("abort_ready", int'(ready[0]), 1);
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_valid", int'(valid[0]), 0);
        tick(5);

        // Inst 1: MAX_ITER=4, never converges -> valid at k+15, timeout
        launch(1, 15, 4, 1, 0, k);
        wait_valid(1, 100);
        ack(1);

        // Inst 2: PU_LATENCY=0, converge after 3 updates -> valid at k+9
        done_at[2] = 3;
        launch(2, 9, 3, 0, 0, k);
        count_pulses(2, 3, 2, 3, k);
        ack(2);

        tick(5);
        chk("results_pending", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
